// File: rtl/xcvr_pkg.sv
// Shared types and constants for the bus transceiver sequencer.
// Included by bus_xcvr_seq and xcvr_dead_timer.
package xcvr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    DRIVE = 2'd2,
    TURN  = 2'd3
  } xcvr_state_e;

  localparam logic DIR_A2B = 1'b1;
  localparam logic DIR_B2A = 1'b0;

  localparam int XCVR_TMR_W = 4;

  // The timer holds the cycles left after the current one.
  function automatic logic [XCVR_TMR_W-1:0] tmr_ld(input int cyc);
    return XCVR_TMR_W'(cyc - 1);
  endfunction

endpackage

// File: rtl/xcvr_dead_timer.sv
// Load/decrement dead-time counter shared by the SETUP and TURN states.
// zero_o flags the last cycle of the loaded interval.
module xcvr_dead_timer
  import xcvr_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic [XCVR_TMR_W-1:0] load_val_i,
  input  logic                  dec_i,
  output logic                  zero_o
);

  logic [XCVR_TMR_W-1:0] cnt_q;
  logic [XCVR_TMR_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (dec_i && cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/bus_xcvr_seq.sv
// Sequencer/datapath for an 8-bit '245-style bidirectional transceiver.
// Define XCVR_BUSHOLD_EN to keep a_out/b_out after a drive ends.
module bus_xcvr_seq
  import xcvr_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int TURN_CYC  = 2,
  parameter int SETUP_CYC = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dir_req,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic             a_oe,
  output logic             b_oe,
  output logic             dir,
  output logic             oen,
  output logic             busy,
  output logic             xfer_ok
);

  localparam logic [XCVR_TMR_W-1:0] SETUP_LD = tmr_ld(SETUP_CYC);
  localparam logic [XCVR_TMR_W-1:0] TURN_LD  = tmr_ld(TURN_CYC);

  xcvr_state_e state_q, state_d;
  logic dir_q, dir_d;
  logic oen_q, a_oe_q, b_oe_q;
  logic busy_q, xfer_ok_q;
  logic [WIDTH-1:0] a_out_q, b_out_q;

  logic                  tmr_load;
  logic [XCVR_TMR_W-1:0] tmr_val;
  logic                  tmr_dec;
  logic                  tmr_zero;
  logic                  hold_ok;

  assign hold_ok = en && (dir_req == dir_q);
  assign tmr_dec = (state_q == SETUP) || (state_q == TURN);

  xcvr_dead_timer u_tmr (
    .clk       (clk),
    .rst       (reset),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .dec_i     (tmr_dec),
    .zero_o    (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state_q)
      IDLE: begin
        if (en) begin
          state_d  = SETUP;
          dir_d    = dir_req;
          tmr_load = 1'b1;
          tmr_val  = SETUP_LD;
        end
      end
      SETUP: begin
        if (!hold_ok) begin
          state_d  = TURN;
          tmr_load = 1'b1;
          tmr_val  = TURN_LD;
        end else if (tmr_zero) begin
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (!hold_ok) begin
          state_d  = TURN;
          tmr_load = 1'b1;
          tmr_val  = TURN_LD;
        end
      end
      TURN: begin
        // Requests seen mid-turnaround wait for the full dead time.
        if (tmr_zero) begin
          if (en) begin
            state_d  = SETUP;
            dir_d    = dir_req;
            tmr_load = 1'b1;
            tmr_val  = SETUP_LD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      dir_q     <= DIR_B2A;
      oen_q     <= 1'b1;
      a_oe_q    <= 1'b0;
      b_oe_q    <= 1'b0;
      busy_q    <= 1'b0;
      xfer_ok_q <= 1'b0;
      a_out_q   <= '0;
      b_out_q   <= '0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      busy_q    <= (state_d != IDLE);
      xfer_ok_q <= (state_q == SETUP) && (state_d == DRIVE);
      oen_q     <= (state_d != DRIVE);
      a_oe_q    <= (state_d == DRIVE) && (dir_d == DIR_B2A);
      b_oe_q    <= (state_d == DRIVE) && (dir_d == DIR_A2B);
      if (state_q == DRIVE && state_d == DRIVE) begin
        if (dir_q == DIR_A2B)
          b_out_q <= a_in;
        else
          a_out_q <= b_in;
      end
`ifndef XCVR_BUSHOLD_EN
      else if (state_d != DRIVE) begin
        a_out_q <= '0;
        b_out_q <= '0;
      end
`endif
    end
  end

  assign a_out   = a_out_q;
  assign b_out   = b_out_q;
  assign a_oe    = a_oe_q;
  assign b_oe    = b_oe_q;
  assign dir     = dir_q;
  assign oen     = oen_q;
  assign busy    = busy_q;
  assign xfer_ok = xfer_ok_q;

  a_no_overlap: assert property (@(posedge clk) disable iff (reset)
    !(a_oe_q && b_oe_q));

  a_oen_oe: assert property (@(posedge clk) disable iff (reset)
    !oen_q |-> ((a_oe_q ^ b_oe_q) && (b_oe_q == dir_q)));

  a_dir_stable: assert property (@(posedge clk) disable iff (reset)
    (!oen_q || !$past(oen_q)) |-> $stable(dir_q));

endmodule
